// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and field positions
// for the commit-stage exception controller.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int unsigned STATUS_IE     = 0;
    localparam int unsigned STATUS_EXL    = 1;
    localparam int unsigned STATUS_IM_LO  = 8;
    localparam int unsigned STATUS_BEV    = 22;
    localparam int unsigned CAUSE_EXC_LO  = 2;
    localparam int unsigned CAUSE_IP_LO   = 8;
    localparam int unsigned CAUSE_TI      = 30;
    localparam int unsigned CAUSE_BD      = 31;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    // Source of the BadVAddr update on an exception commit
    typedef enum logic [1:0] {
        BadKeep,
        BadPc,
        BadErr,
        BadEpc
    } badv_sel_e;

    function automatic logic [31:0] status_word(input logic [7:0] im, input logic exl,
                                                input logic ie);
        logic [31:0] w;
        w = STATUS_RESET;
        w[STATUS_IM_LO +: 8] = im;
        w[STATUS_EXL] = exl;
        w[STATUS_IE] = ie;
        return w;
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_irq_sync.sv
// Parametrised N-wide, depth-D flop synchroniser; depth 0 is a plain wire.
module irq_sync #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_flops
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Commit-stage exception prioritisation together with the CP0 registers it
// updates (Status, Cause, EPC, BadVAddr, Count, Compare) and the MTC0/MFC0 port.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int unsigned N_HW_IRQ   = 6,
    parameter int unsigned TIMER_LINE = 5,
    parameter int unsigned IRQ_SYNC   = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [31:0]         pc,
    input  logic                is_ds,
    input  logic                is_eret,
    input  logic                f_adel_if,
    input  logic                f_reserved,
    input  logic                f_ov,
    input  logic                f_sys,
    input  logic                f_bp,
    input  logic                f_mem_ae,
    input  logic                mem_write,
    input  logic [31:0]         err_addr,
    input  logic [N_HW_IRQ-1:0] hw_irq,
    input  logic                stall,
    input  logic                cp0_we,
    input  logic [4:0]          cp0_waddr,
    input  logic [31:0]         cp0_wdata,
    input  logic [4:0]          cp0_raddr,
    output logic [31:0]         cp0_rdata,
    output logic                exc_flush,
    output logic [31:0]         exc_target,
    output logic                timer_int
);

    logic [N_HW_IRQ-1:0] irq_synced;

    irq_sync #(
        .WIDTH (N_HW_IRQ),
        .DEPTH (IRQ_SYNC)
    ) u_irq_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (hw_irq),
        .dout (irq_synced)
    );

    logic [7:0]  status_im_q, status_im_d;
    logic        status_exl_q, status_exl_d;
    logic        status_ie_q, status_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [1:0]  cause_ip_sw_q, cause_ip_sw_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        phase_q;
    logic        timer_int_q, timer_int_d;
    logic        flush_q;
    logic [31:0] target_q, target_d;

    logic [5:0] ip_hw;
    logic [7:0] cause_ip;

    always_comb begin
        ip_hw = '0;
        for (int unsigned i = 0; i < N_HW_IRQ; i++) begin
            ip_hw[i] = irq_synced[i];
        end
        ip_hw[TIMER_LINE] = ip_hw[TIMER_LINE] | timer_int_q;
    end

    assign cause_ip = {ip_hw, cause_ip_sw_q};

    logic      exc_live, int_pend;
    logic      exc_hit;
    logic [4:0] exc_code;
    badv_sel_e exc_badv_sel;

    assign exc_live = valid & ~status_exl_q;
    assign int_pend = (|(cause_ip & status_im_q)) & status_ie_q & exc_live;

    always_comb begin
        exc_hit      = 1'b1;
        exc_code     = EXC_INT;
        exc_badv_sel = BadKeep;
        if (int_pend) begin
            exc_code = EXC_INT;
        end else if (exc_live && f_adel_if) begin
            exc_code     = EXC_ADEL;
            exc_badv_sel = BadPc;
        end else if (exc_live && f_reserved) begin
            exc_code = EXC_RI;
        end else if (exc_live && f_ov) begin
            exc_code = EXC_OV;
        end else if (exc_live && f_sys) begin
            exc_code = EXC_SYS;
        end else if (exc_live && f_bp) begin
            exc_code = EXC_BP;
        end else if (exc_live && f_mem_ae) begin
            exc_code     = mem_write ? EXC_ADES : EXC_ADEL;
            exc_badv_sel = BadErr;
        end else begin
            exc_hit = 1'b0;
        end
    end

    // ERET is not masked by EXL: it normally runs with EXL set
    logic eret_go, eret_bad;
    logic take_exc, take_eret, flush_event, mtc0_go;
    badv_sel_e badv_sel;

    assign eret_go     = valid & is_eret & ~exc_hit;
    assign eret_bad    = eret_go & (epc_q[1:0] != 2'b00);
    assign take_exc    = ~stall & (exc_hit | eret_bad);
    assign take_eret   = ~stall & eret_go & ~eret_bad;
    assign flush_event = take_exc | take_eret;
    // An MTC0 alongside a flush belongs to the flushed instruction
    assign mtc0_go     = cp0_we & ~stall & ~flush_event;
    assign badv_sel    = exc_hit ? exc_badv_sel : BadEpc;

    always_comb begin
        status_im_d   = status_im_q;
        status_exl_d  = status_exl_q;
        status_ie_d   = status_ie_q;
        cause_bd_d    = cause_bd_q;
        cause_ip_sw_d = cause_ip_sw_q;
        cause_exc_d   = cause_exc_q;
        epc_d         = epc_q;
        badvaddr_d    = badvaddr_q;
        compare_d     = compare_q;
        target_d      = target_q;
        count_d       = count_q + {31'b0, phase_q};
        timer_int_d   = timer_int_q | ((count_q == compare_q) & (compare_q != '0));

        if (mtc0_go) begin
            case (cp0_waddr)
                CP0_COUNT:   count_d = cp0_wdata;
                CP0_COMPARE: begin
                    compare_d   = cp0_wdata;
                    timer_int_d = 1'b0;
                end
                CP0_STATUS: begin
                    status_im_d  = cp0_wdata[STATUS_IM_LO +: 8];
                    status_exl_d = cp0_wdata[STATUS_EXL];
                    status_ie_d  = cp0_wdata[STATUS_IE];
                end
                CP0_CAUSE:   cause_ip_sw_d = cp0_wdata[CAUSE_IP_LO +: 2];
                CP0_EPC:     epc_d = cp0_wdata;
                default:     ;
            endcase
        end

        if (take_exc) begin
            status_exl_d = 1'b1;
            cause_bd_d   = is_ds;
            cause_exc_d  = exc_hit ? exc_code : EXC_ADEL;
            if (exc_hit) begin
                epc_d = is_ds ? (pc - 32'd4) : pc;
            end
            case (badv_sel)
                BadPc:   badvaddr_d = pc;
                BadErr:  badvaddr_d = err_addr;
                BadEpc:  badvaddr_d = epc_q;
                default: ;
            endcase
            target_d = EXC_VECTOR;
        end else if (take_eret) begin
            status_exl_d = 1'b0;
            target_d     = epc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_im_q   <= '0;
            status_exl_q  <= 1'b0;
            status_ie_q   <= 1'b0;
            cause_bd_q    <= 1'b0;
            cause_ip_sw_q <= '0;
            cause_exc_q   <= '0;
            epc_q         <= '0;
            badvaddr_q    <= '0;
            count_q       <= '0;
            compare_q     <= '0;
            phase_q       <= 1'b0;
            timer_int_q   <= 1'b0;
            flush_q       <= 1'b0;
            target_q      <= '0;
        end else begin
            status_im_q   <= status_im_d;
            status_exl_q  <= status_exl_d;
            status_ie_q   <= status_ie_d;
            cause_bd_q    <= cause_bd_d;
            cause_ip_sw_q <= cause_ip_sw_d;
            cause_exc_q   <= cause_exc_d;
            epc_q         <= epc_d;
            badvaddr_q    <= badvaddr_d;
            count_q       <= count_d;
            compare_q     <= compare_d;
            phase_q       <= ~phase_q;
            timer_int_q   <= timer_int_d;
            flush_q       <= flush_event;
            target_q      <= target_d;
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            CP0_BADVADDR: cp0_rdata = badvaddr_q;
            CP0_COUNT:    cp0_rdata = count_q;
            CP0_COMPARE:  cp0_rdata = compare_q;
            CP0_STATUS:   cp0_rdata = status_word(status_im_q, status_exl_q, status_ie_q);
            CP0_CAUSE:    cp0_rdata = {cause_bd_q, timer_int_q, 14'b0, cause_ip, 1'b0,
                                       cause_exc_q, 2'b0};
            CP0_EPC:      cp0_rdata = epc_q;
            default:      cp0_rdata = '0;
        endcase
    end

    assign exc_flush  = flush_q;
    assign exc_target = target_q;
    assign timer_int  = timer_int_q;

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Parametrised successor to the pipeline's combinational exception detector. Merges exception prioritisation with the CP0 state it updates: Status, Cause, EPC, BadVAddr, Count and Compare.
- Sits at the writeback/commit stage. Takes per-instruction fault flags and interrupt lines, and produces flush plus redirect to the pipeline.
- Generalised interrupt width. Adds an internal Count/Compare timer interrupt, synchronised interrupt inputs and an MTC0/MFC0 port.

Parameters:
- N_HW_IRQ, 6, number of external hardware interrupt lines; 1..6. Lines map to Cause.IP[2+N_HW_IRQ-1:2]; unused IP bits read 0.
- TIMER_LINE, 5, hardware IP index (0-based from IP2) that the timer interrupt ORs into.
- IRQ_SYNC, 2, synchroniser depth for hw_irq; 0 means pass-through.
- EXC_VECTOR, 32'hBFC00380, redirect target on any exception.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid  in  1  the instruction at commit is real (not a bubble)
- pc  in  32  PC of the committing instruction
- is_ds  in  1  instruction is in a branch delay slot
- is_eret  in  1  ERET committing
- f_adel_if  in  1  instruction-fetch address error
- f_reserved  in  1  reserved instruction
- f_ov  in  1  arithmetic overflow
- f_sys  in  1  syscall
- f_bp  in  1  break
- f_mem_ae  in  1  data address error
- mem_write  in  1  the faulting memory access is a store
- err_addr  in  32  faulting data address
- hw_irq  in  N_HW_IRQ  external interrupt lines, level-sensitive
- stall  in  1  commit stage stalled
- cp0_we  in  1  MTC0 write enable
- cp0_waddr  in  5  MTC0 register number (sel 0)
- cp0_wdata  in  32  MTC0 data
- cp0_raddr  in  5  MFC0 register number
- cp0_rdata  out  32  combinational read data
- exc_flush  out  1  one-cycle pulse: flush the pipeline and redirect
- exc_target  out  32  redirect PC: EXC_VECTOR, or EPC for ERET
- timer_int  out  1  registered timer interrupt state

Behaviour:
Reset values:
- Status = 32'h0040_0000 (BEV=1); Cause, EPC, BadVAddr, Count, Compare = 0.
- Count phase bit = 0; synchroniser flops = 0; timer_int = 0.
- exc_flush = 0; exc_target = 0.

Interrupt path:
- hw_irq passes through IRQ_SYNC flops into Cause.IP hardware bits, one update per cycle. This adds IRQ_SYNC cycles of latency.
- Cause.IP[1:0] is written only by MTC0.

Timer:
- Count increments every second cycle, using the phase bit.
- timer_int is set when Count == Compare and Compare != 0.
- timer_int is cleared only by an MTC0 write to Compare, including when that write happens in the same cycle as a match.
- An MTC0 to Count overrides the increment for that cycle.

Interrupt decision:
- int_pend = |(Cause.IP & Status.IM) & Status.IE & ~Status.EXL & valid.

Exception priority, first match wins:
- interrupt (ExcCode 0)
- f_adel_if (4)
- f_reserved (10)
- f_ov (12)
- f_sys (8)
- f_bp (9)
- f_mem_ae && !mem_write (4)
- f_mem_ae && mem_write (5)
- Any of these is qualified by valid and by !Status.EXL.

Exception commit, in a cycle with !stall:
- exc_flush=1 and exc_target=EXC_VECTOR, registered, so both appear the cycle after detection.
- Status.EXL is set.
- Cause.ExcCode and Cause.BD=is_ds are written.
- EPC = is_ds ? pc-4 : pc.
- BadVAddr = pc for an ADEL fetch, err_addr for a data error; otherwise unchanged.

ERET, valid with no higher exception:
- exc_flush=1, exc_target=EPC, EXL is cleared next cycle.
- ERET with EPC[1:0]!=0 instead raises AdEL: BadVAddr=EPC, EPC left unchanged.

Stall handling:
- stall=1 suppresses every commit and ERET update.
- Count and the synchronisers keep running.

Simultaneous events:
- An exception commit and an MTC0 in the same cycle: the exception wins for EPC, Cause and Status.EXL. The MTC0 is discarded, because it belongs to the flushed instruction.

Writable fields:
- Status: IM, EXL, IE.
- Cause: IP[1:0] only.
- EPC, Count and Compare: full width.
- All other fields are read-only.

Read port:
- cp0_rdata returns {Cause.BD, timer_int as Cause.TI (bit 30), IP, ExcCode} for Cause.
- Addresses BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14; any other address reads 0.

Decomposition:
- Package cp0_pkg holds: register numbers, ExcCode constants, Status/Cause bit positions, and the reset value of Status.
- Sub-module irq_sync: a parametrised N-wide, depth-D synchroniser.

Test Plan:
1. IRQ: Status=32'h0000_0401 (IM2, IE), hw_irq[0]=1 -> Cause.IP2 set after 2 cycles; exc_flush pulse; ExcCode=0; EPC=pc; EXL=1.
2. Timer: Compare=10, Count=0 -> timer_int rises after Count reaches 10 (about 20 cycles); MTC0 to Compare clears it the next cycle.
3. Priority: f_ov=1, f_sys=1, is_ds=1, pc=32'h8000_0104 -> ExcCode=12, BD=1, EPC=32'h8000_0100.
4. Store error: f_mem_ae=1, mem_write=1, err_addr=32'h8000_0003 -> ExcCode=5, BadVAddr=32'h8000_0003.
5. ERET: EPC=32'h8000_0200, EXL=1 -> exc_target=32'h8000_0200, EXL=0. Then with EPC=32'h8000_0202 -> ExcCode=4, BadVAddr=32'h8000_0202.
6. Stall/EXL: a fault asserted while stall=1, or while EXL=1 -> no flush and no CP0 change; Count still increments.
